// File: rtl/gauss_frame_ctrl_pkg.sv
// Shared types and constants for the Gaussian frame sequencer: FSM states,
// 3x3 window indices and the per-index neighbour offsets.
package gauss_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FILT,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam logic [3:0] K_TL = 4'd0;
  localparam logic [3:0] K_T  = 4'd1;
  localparam logic [3:0] K_TR = 4'd2;
  localparam logic [3:0] K_L  = 4'd3;
  localparam logic [3:0] K_C  = 4'd4;
  localparam logic [3:0] K_R  = 4'd5;
  localparam logic [3:0] K_BL = 4'd6;
  localparam logic [3:0] K_B  = 4'd7;
  localparam logic [3:0] K_BR = 4'd8;

  localparam int DEF_FILT_LAT = 40;

  function automatic logic signed [1:0] k_dx(input logic [3:0] k);
    case (k)
      K_TL, K_L, K_BL: k_dx = -2'sd1;
      K_TR, K_R, K_BR: k_dx = 2'sd1;
      default:         k_dx = 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] k_dy(input logic [3:0] k);
    case (k)
      K_TL, K_T, K_TR: k_dy = -2'sd1;
      K_BL, K_B, K_BR: k_dy = 2'sd1;
      default:         k_dy = 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/gauss_frame_ctrl_if.sv
// RAM and filter bus of the Gaussian frame sequencer; master is the sequencer,
// slave is the side holding the frame buffers and the filter.
interface gauss_frame_ctrl_if #(parameter int ADDR_W = 14);
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [7:0]        rd_data_i;
  logic [71:0]       win_o;
  logic              filt_en_o;
  logic [7:0]        filt_data_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;

  modport master (
    output rd_en_o, rd_addr_o, win_o, filt_en_o, wr_en_o, wr_addr_o, wr_data_o,
    input  rd_data_i, filt_data_i
  );

  modport slave (
    input  rd_en_o, rd_addr_o, win_o, filt_en_o, wr_en_o, wr_addr_o, wr_data_o,
    output rd_data_i, filt_data_i
  );
endinterface

// File: rtl/gauss_frame_ctrl_addr_gen.sv
// Raster position tracker: clamped neighbour address for window index k.
// GAUSS_BORDER_COPY_EN enables skip_o on border pixels (else skip_o is 0).
module gauss_addr_gen
  import gauss_ctrl_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_i,
  input  logic [3:0]        k_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              skip_o,
  output logic              last_o
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [ADDR_W-1:0] row_q;
  logic              x_min, x_max, y_min, y_max;
  logic [ADDR_W-1:0] col, row;

  assign x_min  = (x_q == '0);
  assign x_max  = (x_q == XW'(IMG_W - 1));
  assign y_min  = (y_q == '0);
  assign y_max  = (y_q == YW'(IMG_H - 1));
  assign last_o = x_max && y_max;

`ifdef GAUSS_BORDER_COPY_EN
  assign skip_o = x_min || x_max || y_min || y_max;
`else
  assign skip_o = 1'b0;
`endif

  // Edge replicate: an offset that would leave the image is dropped.
  always_comb begin
    col = ADDR_W'(x_q);
    row = row_q;
    if (k_dx(k_i) < 0 && !x_min) col = col - 1'b1;
    if (k_dx(k_i) > 0 && !x_max) col = col + 1'b1;
    if (k_dy(k_i) < 0 && !y_min) row = row - ADDR_W'(IMG_W);
    if (k_dy(k_i) > 0 && !y_max) row = row + ADDR_W'(IMG_W);
    addr_o = row + col;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      row_q <= '0;
    end else if (step_i) begin
      if (x_max) begin
        x_q <= '0;
        if (y_max) begin
          y_q   <= '0;
          row_q <= '0;
        end else begin
          y_q   <= y_q + 1'b1;
          row_q <= row_q + ADDR_W'(IMG_W);
        end
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer for the 3x3 Gaussian filter: fetch window, hold filter enable,
// write result, raster order. GAUSS_BORDER_COPY_EN copies border pixels unfiltered.
module gauss_frame_ctrl
  import gauss_ctrl_pkg::*;
#(
  parameter int IMG_W    = 128,
  parameter int IMG_H    = 128,
  parameter int ADDR_W   = 14,
  parameter int FILT_LAT = DEF_FILT_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  gauss_frame_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(FILT_LAT + 10);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [8:0][7:0]   win_q;
  logic              busy_q, done_q, rd_en_q, filt_en_q, wr_en_q, last_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [ADDR_W-1:0] addr;
  logic              skip, last, step_d, fetch_end, filt_end;
  logic [3:0]        k_d;

  gauss_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk), .rst(rst), .step_i(step_d), .k_i(k_d),
    .addr_o(addr), .skip_o(skip), .last_o(last)
  );

  assign fetch_end = skip ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(9));
  assign filt_end  = (cnt_q == CNT_W'(FILT_LAT - 1));
  assign step_d    = (state_q == ST_FETCH && skip && fetch_end) ||
                     (state_q == ST_FILT && filt_end);

  // Address is prepared one cycle ahead of the strobe that carries it.
  always_comb begin
    k_d = K_TL;
    case (state_q)
      ST_IDLE, ST_WRITE: k_d = skip ? K_C : K_TL;
      ST_FETCH:          k_d = skip ? K_C : 4'(cnt_q) + 4'd1;
      ST_FILT:           k_d = K_C;
      default:           k_d = K_TL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      filt_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_q   <= ST_FETCH;
          cnt_q     <= '0;
          busy_q    <= 1'b1;
          rd_en_q   <= 1'b1;
          rd_addr_q <= addr;
        end
        ST_FETCH: begin
          cnt_q <= cnt_q + 1'b1;
          if (skip) begin
            rd_en_q <= 1'b0;
            if (fetch_end) begin
              state_q   <= ST_WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr;
              wr_data_q <= rd_data_sel();
              last_q    <= last;
            end
          end else begin
            if (cnt_q != '0) win_q[4'(cnt_q) - 4'd1] <= bus.rd_data_i;
            if (cnt_q < CNT_W'(8)) rd_addr_q <= addr;
            if (cnt_q == CNT_W'(8)) rd_en_q <= 1'b0;
            if (fetch_end) begin
              state_q   <= ST_FILT;
              cnt_q     <= '0;
              filt_en_q <= 1'b1;
            end
          end
        end
        ST_FILT: begin
          cnt_q <= cnt_q + 1'b1;
          if (filt_end) begin
            state_q   <= ST_WRITE;
            filt_en_q <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr;
            wr_data_q <= bus.filt_data_i;
            last_q    <= last;
          end
        end
        ST_WRITE: begin
          wr_en_q <= 1'b0;
          cnt_q   <= '0;
          if (last_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= ST_FETCH;
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [7:0] rd_data_sel();
    return bus.rd_data_i;
  endfunction

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_addr_o = rd_addr_q;
  assign bus.win_o     = win_q;
  assign bus.filt_en_o = filt_en_q;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// Bench for gauss_frame_ctrl on a 4x4 image: behavioural RAMs and filter,
// reference image model feeding a write scoreboard checked by a monitor.
module tb_gauss_frame_ctrl;
  localparam int W = 4, H = 4, AW = 6, LAT = 40, N = W * H;
  localparam int BUDGET = N * (LAT + 11) + 60;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done;
  always #5 clk = ~clk;

  gauss_frame_ctrl_if #(.ADDR_W(AW)) bus();

  gauss_frame_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FILT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done), .bus(bus)
  );

  logic [7:0] src[N];
  logic [7:0] dst[N];
  int         en_cnt = 0;

  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= src[int'(bus.rd_addr_o) % N];
  always @(posedge clk) if (bus.wr_en_o) dst[int'(bus.wr_addr_o) % N] <= bus.wr_data_o;
  always @(posedge clk) en_cnt <= bus.filt_en_o ? en_cnt + 1 : 0;

  // Filter model: result is only meaningful on the LAT-th enabled cycle.
  function automatic logic [7:0] filt_win(input logic [71:0] w);
    int s = 0;
    for (int k = 0; k < 9; k++)
      s += int'(w[8*k +: 8]) * ((k == 4) ? 4 : (k % 2 == 1) ? 2 : 1);
    return 8'(s >> 4);
  endfunction
  assign bus.filt_data_i = (bus.filt_en_o && en_cnt == LAT - 1) ? filt_win(bus.win_o) : 8'hEE;

  int  vectors = 0, miscompares = 0;
  int  done_cnt = 0, wr_total = 0, busy_cyc = 0, exp_busy = 0;
  wr_t exp_q[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  function automatic int pix(input int x, input int y);
    return int'(src[clampi(y, H - 1) * W + clampi(x, W - 1)]);
  endfunction

  function automatic bit is_border(input int x, input int y);
`ifdef GAUSS_BORDER_COPY_EN
    return (x == 0 || y == 0 || x == W - 1 || y == H - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] ref_pix(input int x, input int y);
    int s = 0;
    if (is_border(x, y)) return 8'(pix(x, y));
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        s += pix(x + dx, y + dy) * (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
    return 8'(s / 16);
  endfunction

  task automatic push_expected();
    exp_busy = 1;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        exp_q.push_back('{a: AW'(y * W + x), d: ref_pix(x, y)});
        exp_busy += is_border(x, y) ? 3 : LAT + 11;
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt;
    for (int i = 0; i < BUDGET && done_cnt == d0; i++) @(posedge clk);
    chk({nm, "_done_seen"}, done_cnt, d0 + 1);
    repeat (5) @(posedge clk);
  endtask

  task automatic check_zero(input string nm);
    #1;
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_rd_en"}, bus.rd_en_o, 0);
    chk({nm, "_rd_addr"}, bus.rd_addr_o, 0);
    chk({nm, "_win"}, bus.win_o, 0);
    chk({nm, "_filt_en"}, bus.filt_en_o, 0);
    chk({nm, "_wr_en"}, bus.wr_en_o, 0);
    chk({nm, "_wr_addr"}, bus.wr_addr_o, 0);
    chk({nm, "_wr_data"}, bus.wr_data_o, 0);
  endtask

  // Monitor: scoreboard pops on each write, frame checks on done.
  initial begin
    logic [71:0] prev_win = '0;
    logic        prev_fen = 1'b0;
    wr_t         e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cyc = 0;
        prev_fen = 1'b0;
      end else begin
        chk("rd_wr_exclusive", bus.rd_en_o & bus.wr_en_o, 0);
        if (bus.filt_en_o && prev_fen) chk("win_stable", bus.win_o, prev_win);
        prev_fen = bus.filt_en_o;
        prev_win = bus.win_o;
        if (busy) busy_cyc++;
        if (bus.wr_en_o) begin
          wr_total++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: addr %0d data %0d, none required", bus.wr_addr_o, bus.wr_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.wr_addr_o, e.a);
            chk("wr_data", bus.wr_data_o, e.d);
          end
        end
        if (done) begin
          done_cnt++;
          chk("done_pending_writes", exp_q.size(), 0);
          chk("busy_cycles", busy_cyc, exp_busy);
          busy_cyc = 0;
        end
      end
    end
  end

  initial begin
    logic [71:0] ew;
    int          d0, w0;

    // Reset state
    #12 check_zero("rst");
    @(posedge clk); #1 rst = 1'b0;
    check_zero("post_rst");

    // Constant image
    for (int i = 0; i < N; i++) src[i] = 8'd100;
    push_expected(); pulse_start(); wait_done("const");
    chk("const_dst15", dst[15], 100);

    // Impulse at (1,1)
    for (int i = 0; i < N; i++) src[i] = 8'd0;
    src[5] = 8'd160;
    push_expected(); pulse_start(); wait_done("impulse");
    chk("imp_centre", dst[5], 40);
`ifndef GAUSS_BORDER_COPY_EN
    chk("imp_up", dst[1], 20);
    chk("imp_left", dst[4], 20);
    chk("imp_right", dst[6], 20);
    chk("imp_down", dst[9], 20);
    chk("imp_diag_tl", dst[0], 10);
    chk("imp_diag_br", dst[10], 10);
    chk("imp_far", dst[15], 0);
`endif

    // Random image; corner window of pixel (0,0)
    for (int i = 0; i < N; i++) src[i] = 8'($urandom);
    push_expected(); pulse_start();
`ifndef GAUSS_BORDER_COPY_EN
    for (int i = 0; i < 30 && !bus.filt_en_o; i++) @(posedge clk);
    #1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        ew[8*((dy + 1) * 3 + dx + 1) +: 8] = 8'(pix(dx, dy));
    chk("corner_win", bus.win_o, ew);
`endif
    wait_done("corner");

    // start_i held high throughout a frame
    for (int i = 0; i < N; i++) src[i] = 8'($urandom);
    push_expected();
    d0 = done_cnt; w0 = wr_total;
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk); #1;
      if (done) break;
      start = 1'b1;
    end
    start = 1'b0;
    repeat (60) @(posedge clk);
    chk("hold_done_count", done_cnt, d0 + 1);
    chk("hold_write_count", wr_total, w0 + N);
    chk("hold_idle_busy", busy, 0);

    // Reset in the middle of pixel 5's filter phase
    for (int i = 0; i < N; i++) src[i] = 8'($urandom);
    push_expected(); pulse_start();
    w0 = wr_total;
    for (int i = 0; i < BUDGET && wr_total < w0 + 5; i++) @(posedge clk);
    for (int i = 0; i < 30 && !bus.filt_en_o; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    check_zero("mid_rst");
    w0 = wr_total;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_no_write", wr_total, w0);
    exp_q.delete();
    push_expected(); pulse_start(); wait_done("restart");

    // Ramp image and extra random frames
    for (int i = 0; i < N; i++) src[i] = 8'(i * 10);
    push_expected(); pulse_start(); wait_done("ramp");
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) src[i] = 8'($urandom_range(0, 255));
      push_expected(); pulse_start(); wait_done("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
